fxp_sqrt_arbiter: RTL and testbench

- Shares one combinational fixed-point square-root unit (comb_FixedPointSqrt, ROOF=1, ROUND=1) among NREQ requesters.
- Round-robin arbitration, a registered issue stage, a registered result stage and valid/ready backpressure on the single response port.
- Sits between client blocks (filters, norm/magnitude units) and the sqrt datapath, so only one sqrt instance is spent per cluster.

---
 rtl/fxp_sqrt_arbiter.sv | 252 +++++++++++++++++++++++++
 tb/tb_fxp_sqrt_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fxp_sqrt_arbiter.sv
// Round-robin arbiter sharing one combinational fixed-point square-root unit
// among NREQ requesters, with registered issue/result stages and output backpressure.

module comb_FixedPointSqrt #(
    parameter int WII   = 8,
    parameter int WIF   = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [WII+WIF-1:0] in_data,
    output logic [WOI+WOF-1:0] out_data,
    output logic               upflow,
    output logic               downflow
);
    localparam int WI   = WII + WIF;
    localparam int WO   = WOI + WOF;
    localparam int MW   = WI - 1;
    // Two extra radicand bits give one extra root bit, used for rounding.
    localparam int SH   = 2 * WOF - WIF + 2;
    localparam int RW   = (SH >= 0) ? MW + SH : MW;
    localparam int NW   = RW + (RW % 2);
    localparam int HALF = NW / 2;
    localparam int RMW  = HALF + 3;
    localparam int CW   = ((HALF > WO) ? HALF : WO) + 1;
    localparam logic [CW-1:0] MAXW = CW'((64'd1 << (WO - 1)) - 64'd1);

    logic            neg;
    logic [MW-1:0]   mag;
    logic [NW-1:0]   rad;
    logic [NW-1:0]   radw;
    logic [RMW-1:0]  rem;
    logic [RMW-1:0]  trial;
    logic [HALF-1:0] root;
    logic [HALF:0]   rnd;
    logic [HALF-1:0] q;
    logic [CW-1:0]   qw;

    assign neg = in_data[WI-1];
    assign mag = in_data[MW-1:0];

    generate
        if (SH >= 0) begin : g_shl
            assign rad = NW'(mag) << SH;
        end else begin : g_shr
            assign rad = NW'(mag >> (-SH));
        end
    endgenerate

    // Digit-by-digit integer square root, two radicand bits per step.
    always_comb begin
        rem   = '0;
        trial = '0;
        root  = '0;
        radw  = rad;
        for (int unsigned k = 0; k < HALF; k++) begin
            rem   = {rem[RMW-3:0], radw[NW-1 -: 2]};
            radw  = radw << 2;
            trial = RMW'({root, 2'b01});
            if (rem >= trial) begin
                rem  = rem - trial;
                root = {root[HALF-2:0], 1'b1};
            end else begin
                root = {root[HALF-2:0], 1'b0};
            end
        end
    end

    assign rnd = {1'b0, root} + ((ROUND != 0) ? (HALF+1)'(1) : (HALF+1)'(0));
    assign q   = HALF'(rnd >> 1);
    assign qw  = CW'(q);

    always_comb begin
        upflow   = 1'b0;
        downflow = 1'b0;
        out_data = '0;
        if (!neg) begin
            if (qw > MAXW) begin
                upflow   = 1'b1;
                out_data = (ROOF != 0) ? MAXW[WO-1:0] : qw[WO-1:0];
            end else begin
                out_data = qw[WO-1:0];
            end
            downflow = (mag != '0) && (qw == '0);
        end
    end
endmodule

module fxp_sqrt_arbiter #(
    parameter int NREQ = 4,
    parameter int WII  = 13,
    parameter int WIF  = 13,
    parameter int WOI  = 10,
    parameter int WOF  = 13,
    localparam int WI  = WII + WIF,
    localparam int WO  = WOI + WOF,
    localparam int IDW = ($clog2(NREQ) < 1) ? 1 : $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*WI-1:0] req_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [IDW-1:0]     out_id,
    output logic [WO-1:0]      out_sqrt,
    output logic               out_upflow,
    output logic               out_downflow,
    output logic               out_neg,
    output logic [1:0]         inflight
);
    logic           s1_valid_q, s1_valid_d;
    logic [WI-1:0]  s1_data_q,  s1_data_d;
    logic [IDW-1:0] s1_id_q,    s1_id_d;

    logic           out_valid_q,    out_valid_d;
    logic [IDW-1:0] out_id_q,       out_id_d;
    logic [WO-1:0]  out_sqrt_q,     out_sqrt_d;
    logic           out_upflow_q,   out_upflow_d;
    logic           out_downflow_q, out_downflow_d;
    logic           out_neg_q,      out_neg_d;

    logic [IDW-1:0] last_q,     last_d;
    logic [1:0]     inflight_q, inflight_d;

    logic           drain, s2_load, accept, gnt_found, handshake;
    logic [IDW-1:0] gnt_id;
    logic [IDW:0]   cand;
    logic [WI-1:0]  gnt_data;

    logic [WO-1:0]  sq_out;
    logic           sq_up, sq_dn, s1_neg;

    comb_FixedPointSqrt #(
        .WII   (WII),
        .WIF   (WIF),
        .WOI   (WOI),
        .WOF   (WOF),
        .ROOF  (1),
        .ROUND (1)
    ) u_sqrt (
        .in_data  (s1_data_q),
        .out_data (sq_out),
        .upflow   (sq_up),
        .downflow (sq_dn)
    );

    assign s1_neg = s1_data_q[WI-1];

    always_comb begin
        drain   = out_valid_q & out_ready;
        s2_load = s1_valid_q & (~out_valid_q | drain);
        accept  = ~s1_valid_q | s2_load;

        // Rotating search starting just after the last granted requester.
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_id    = cand[IDW-1:0];
            end
        end
        handshake = accept & gnt_found;

        gnt_data  = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_id == IDW'(i)) begin
                gnt_data     = req_data[i*WI +: WI];
                req_ready[i] = handshake;
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_id_d    = s1_id_q;
        last_d     = last_q;
        if (handshake) begin
            s1_valid_d = 1'b1;
            s1_data_d  = gnt_data;
            s1_id_d    = gnt_id;
            last_d     = gnt_id;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        out_valid_d    = out_valid_q;
        out_id_d       = out_id_q;
        out_sqrt_d     = out_sqrt_q;
        out_upflow_d   = out_upflow_q;
        out_downflow_d = out_downflow_q;
        out_neg_d      = out_neg_q;
        if (s2_load) begin
            out_valid_d    = 1'b1;
            out_id_d       = s1_id_q;
            out_neg_d      = s1_neg;
            out_sqrt_d     = s1_neg ? '0 : sq_out;
            out_upflow_d   = s1_neg ? 1'b0 : sq_up;
            out_downflow_d = s1_neg ? 1'b0 : sq_dn;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end

        inflight_d = {1'b0, s1_valid_d} + {1'b0, out_valid_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q     <= 1'b0;
            s1_data_q      <= '0;
            s1_id_q        <= '0;
            out_valid_q    <= 1'b0;
            out_id_q       <= '0;
            out_sqrt_q     <= '0;
            out_upflow_q   <= 1'b0;
            out_downflow_q <= 1'b0;
            out_neg_q      <= 1'b0;
            last_q         <= IDW'(NREQ - 1);
            inflight_q     <= '0;
        end else begin
            s1_valid_q     <= s1_valid_d;
            s1_data_q      <= s1_data_d;
            s1_id_q        <= s1_id_d;
            out_valid_q    <= out_valid_d;
            out_id_q       <= out_id_d;
            out_sqrt_q     <= out_sqrt_d;
            out_upflow_q   <= out_upflow_d;
            out_downflow_q <= out_downflow_d;
            out_neg_q      <= out_neg_d;
            last_q         <= last_d;
            inflight_q     <= inflight_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_id       = out_id_q;
    assign out_sqrt     = out_sqrt_q;
    assign out_upflow   = out_upflow_q;
    assign out_downflow = out_downflow_q;
    assign out_neg      = out_neg_q;
    assign inflight     = inflight_q;
endmodule

// File: tb/tb_fxp_sqrt_arbiter.sv
// Self-checking bench for fxp_sqrt_arbiter: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based reference model using real-valued sqrt.

module tb_fxp_sqrt_arbiter;
    localparam int NREQ = 4;
    localparam int WII  = 13;
    localparam int WIF  = 13;
    localparam int WOI  = 10;
    localparam int WOF  = 13;
    localparam int WI   = WII + WIF;
    localparam int WO   = WOI + WOF;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*WI-1:0] req_data;
    logic               out_valid;
    logic               out_ready;
    logic [IDW-1:0]     out_id;
    logic [WO-1:0]      out_sqrt;
    logic               out_upflow;
    logic               out_downflow;
    logic               out_neg;
    logic [1:0]         inflight;

    always #5 clk = ~clk;

    fxp_sqrt_arbiter #(
        .NREQ (NREQ),
        .WII  (WII),
        .WIF  (WIF),
        .WOI  (WOI),
        .WOF  (WOF)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_sqrt     (out_sqrt),
        .out_upflow   (out_upflow),
        .out_downflow (out_downflow),
        .out_neg      (out_neg),
        .inflight     (inflight)
    );

    typedef struct {
        int     id;
        longint sq;
        bit     neg;
        bit     up;
        bit     dn;
        bit     in_s2;
    } item_t;

    item_t  mq[$];
    int     last;
    int     vectors     = 0;
    int     miscompares = 0;
    int     exp_g;
    bit     exp_acc;
    bit     mv;
    longint held;

    function automatic item_t ref_result(input int id, input logic [WI-1:0] x);
        item_t  it;
        real    s;
        longint r;
        longint maxo;
        maxo     = (longint'(1) << (WO - 1)) - 1;
        it.id    = id;
        it.in_s2 = 1'b0;
        it.up    = 1'b0;
        it.dn    = 1'b0;
        it.neg   = x[WI-1];
        it.sq    = 0;
        if (!it.neg) begin
            s = $sqrt(real'(x) * (2.0 ** (2 * WOF - WIF)));
            r = longint'($floor(s + 0.5));
            if (r > maxo) begin
                it.up = 1'b1;
                r     = maxo;
            end
            if (x != '0 && r == 0) it.dn = 1'b1;
            it.sq = r;
        end
        return it;
    endfunction

    function automatic logic [WI-1:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return WI'($urandom_range(0, 1000));
            1:       return {1'b1, (WI-1)'($urandom)};
            default: return {1'b0, (WI-1)'($urandom)};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        exp_acc = (mq.size() < 2) || out_ready;
        exp_g   = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int i;
            i = (last + k) % NREQ;
            if (exp_g < 0 && bit'(req_valid >> i)) exp_g = i;
        end
        if (!rst) chk("req_ready", 64'(req_ready), (exp_acc && exp_g >= 0) ? (64'd1 << exp_g) : 64'd0);
        mv = (mq.size() > 0) && mq[0].in_s2;
        chk("out_valid", 64'(out_valid), 64'(mv));
        chk("inflight", 64'(inflight), 64'(mq.size()));
        if (mv) begin
            chk("out_id",       64'(out_id),       64'(mq[0].id));
            chk("out_sqrt",     64'(out_sqrt),     64'(mq[0].sq));
            chk("out_neg",      64'(out_neg),      64'(mq[0].neg));
            chk("out_upflow",   64'(out_upflow),   64'(mq[0].up));
            chk("out_downflow", 64'(out_downflow), 64'(mq[0].dn));
        end
    endtask

    task automatic clock();
        if (rst) begin
            mq.delete();
            last = NREQ - 1;
        end else begin
            if (mv && out_ready) void'(mq.pop_front());
            if (mq.size() > 0 && !mq[0].in_s2) mq[0].in_s2 = 1'b1;
            if (exp_acc && exp_g >= 0) begin
                mq.push_back(ref_result(exp_g, req_data[exp_g*WI +: WI]));
                last = exp_g;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        clock();
    endtask

    task automatic set_req(input int i, input logic [WI-1:0] d);
        req_data[i*WI +: WI] = d;
        req_valid = req_valid | (NREQ'(1) << i);
    endtask

    task automatic rand_all_data();
        for (int i = 0; i < NREQ; i++) req_data[i*WI +: WI] = rnd_data();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b1;
        last      = NREQ - 1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        sample();
        chk("rst_out_valid", 64'(out_valid),    64'd0);
        chk("rst_out_id",    64'(out_id),       64'd0);
        chk("rst_out_sqrt",  64'(out_sqrt),     64'd0);
        chk("rst_flags",     64'({out_upflow, out_downflow, out_neg}), 64'd0);
        chk("rst_inflight",  64'(inflight),     64'd0);
        clock();

        // Requester 0, 4.0 -> 2.0
        set_req(0, 26'h0008000);
        sample();
        chk("t1_ready", 64'(req_ready), 64'd1);
        clock();
        req_valid = '0;
        step();
        sample();
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_id",    64'(out_id),    64'd0);
        chk("t1_sqrt",  64'(out_sqrt),  64'h004000);
        chk("t1_neg",   64'(out_neg),   64'd0);
        clock();

        // Requester 2, 2.0 -> 1.41421
        set_req(2, 26'h0004000);
        sample();
        chk("t2_ready", 64'(req_ready), 64'd4);
        clock();
        req_valid = '0;
        step();
        sample();
        chk("t2_sqrt", 64'(out_sqrt), 64'h002D41);
        chk("t2_id",   64'(out_id),   64'd2);
        clock();
        step();

        // Round-robin with all requesters active from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) req_valid = '0;
            rand_all_data();
            sample();
            if (k < 8) chk("rr_grant", 64'(req_ready), 64'd1 << (k % 4));
            if (k >= 2) chk("rr_id", 64'(out_id), 64'((k - 2) % 4));
            clock();
        end
        step();
        step();

        // Backpressure: consumer stalls for 5 cycles under continuous requests
        req_valid = '1;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_all_data();
            sample();
            if (k < 2) begin
                chk("bp_accept", 64'(req_ready != '0), 64'd1);
            end else begin
                if (k == 2) held = mq[0].sq;
                chk("bp_ready0",   64'(req_ready), 64'd0);
                chk("bp_inflight", 64'(inflight),  64'd2);
                chk("bp_hold",     64'(out_sqrt),  64'(held));
            end
            clock();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            rand_all_data();
            step();
        end
        req_valid = '0;
        for (int k = 0; k < 3; k++) step();

        // Requester 1, -1.0
        set_req(1, 26'h3FFE000);
        sample();
        chk("neg_ready", 64'(req_ready), 64'd2);
        clock();
        req_valid = '0;
        step();
        sample();
        chk("neg_flag",  64'(out_neg),      64'd1);
        chk("neg_sqrt",  64'(out_sqrt),     64'd0);
        chk("neg_up",    64'(out_upflow),   64'd0);
        chk("neg_dn",    64'(out_downflow), 64'd0);
        chk("neg_id",    64'(out_id),       64'd1);
        clock();
        step();

        // Reset with a full pipeline after requester 3 was granted
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            rand_all_data();
            sample();
            chk("mr_grant", 64'(req_ready), 64'd1 << k);
            clock();
        end
        rst = 1'b1;
        sample();
        chk("mr_inflight_full", 64'(inflight), 64'd2);
        clock();
        rst = 1'b0;
        sample();
        chk("mr_valid",    64'(out_valid), 64'd0);
        chk("mr_inflight", 64'(inflight),  64'd0);
        chk("mr_grant0",   64'(req_ready), 64'd1);
        clock();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom);
            rand_all_data();
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 99) == 0);
            step();
        end
        rst       = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        sample();
        chk("final_empty", 64'(inflight), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
